// File: rtl/adc_mode_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : adc_mode_sequencer_if
// Brief    : Button inputs and mode-select outputs of the ADC mode sequencer.
//            auto_scan exists only when ADC_MODE_AUTOSCAN_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface adc_mode_sequencer_if #(
  parameter int NUM_MODES = 5,
  parameter int SEL_W     = $clog2(NUM_MODES)
);
  logic                 btn_next;
  logic                 btn_prev;
`ifdef ADC_MODE_AUTOSCAN_EN
  logic                 auto_scan;
`endif
  logic [SEL_W-1:0]     adc_sel;
  logic [NUM_MODES-1:0] mode_en;
  logic                 mode_valid;
  logic                 busy;

  // master: the control side that drives the buttons
  modport master (
    output btn_next, btn_prev,
`ifdef ADC_MODE_AUTOSCAN_EN
    output auto_scan,
`endif
    input  adc_sel, mode_en, mode_valid, busy
  );

  // slave: the sequencer itself
  modport slave (
    input  btn_next, btn_prev,
`ifdef ADC_MODE_AUTOSCAN_EN
    input  auto_scan,
`endif
    output adc_sel, mode_en, mode_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/adc_mode_sequencer.sv
//------------------------------------------------------------------------------
// Module   : adc_mode_sequencer
// Brief    : Steps through NUM_MODES ADC modes from next/prev buttons, blanking
//            all enables for SETTLE_CYCLES after reset or any mode change.
//            Optional dwell-timed auto-advance under ADC_MODE_AUTOSCAN_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adc_mode_sequencer #(
  parameter int NUM_MODES     = 5,
  parameter int RESET_MODE    = 0,
  parameter int SETTLE_CYCLES = 1000,
`ifdef ADC_MODE_AUTOSCAN_EN
  parameter int SCAN_PERIOD   = 100000,
`endif
  parameter int SEL_W         = $clog2(NUM_MODES)
) (
  input  wire logic           clk,
  input  wire logic           reset,
  adc_mode_sequencer_if.slave bus
);

  localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_init  = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0]   c_reset_sel = SEL_W'(RESET_MODE);
  localparam logic [SEL_W-1:0]   c_last_sel  = SEL_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_MODES-1:0] en_q, en_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 btn_next_q, btn_next_d;
  logic                 btn_prev_q, btn_prev_d;
  logic                 nxt, prv, nxt_eff, change;

`ifdef ADC_MODE_AUTOSCAN_EN
  localparam int c_dwell_w = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SCAN_PERIOD - 1);

  logic [c_dwell_w-1:0] dwell_q, dwell_d;
  logic                 auto_fire;
`endif

  always_comb begin
    nxt        = bus.btn_next & ~btn_next_q;
    prv        = bus.btn_prev & ~btn_prev_q;
`ifdef ADC_MODE_AUTOSCAN_EN
    auto_fire  = bus.auto_scan && (state_q == ST_ACTIVE) && (dwell_q == c_dwell_last);
    nxt_eff    = nxt | auto_fire;
`else
    nxt_eff    = nxt;
`endif
    change     = 1'b0;
    state_d    = state_q;
    sel_d      = sel_q;
    en_d       = en_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    btn_next_d = bus.btn_next;
    btn_prev_d = bus.btn_prev;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          en_d    = NUM_MODES'(1) << sel_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q - c_cnt_w'(1);
        end
      end
      ST_ACTIVE: begin
        // simultaneous next and prev cancel out
        if (nxt_eff ^ prv) begin
          change  = 1'b1;
          if (nxt_eff)
            sel_d = (sel_q == c_last_sel) ? '0 : sel_q + SEL_W'(1);
          else
            sel_d = (sel_q == '0) ? c_last_sel : sel_q - SEL_W'(1);
          state_d = ST_SETTLE;
          cnt_d   = c_cnt_init;
          en_d    = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        sel_d   = c_reset_sel;
        cnt_d   = c_cnt_init;
        en_d    = '0;
        valid_d = 1'b0;
        busy_d  = 1'b1;
      end
    endcase

`ifdef ADC_MODE_AUTOSCAN_EN
    // restart the dwell after every auto edge, even one cancelled by prev
    if ((state_q != ST_ACTIVE) || !bus.auto_scan || change || auto_fire)
      dwell_d = '0;
    else
      dwell_d = dwell_q + c_dwell_w'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SETTLE;
      sel_q      <= c_reset_sel;
      en_q       <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b1;
      cnt_q      <= c_cnt_init;
      btn_next_q <= 1'b0;
      btn_prev_q <= 1'b0;
`ifdef ADC_MODE_AUTOSCAN_EN
      dwell_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      btn_next_q <= btn_next_d;
      btn_prev_q <= btn_prev_d;
`ifdef ADC_MODE_AUTOSCAN_EN
      dwell_q    <= dwell_d;
`endif
    end
  end

  assign bus.adc_sel    = sel_q;
  assign bus.mode_en    = en_q;
  assign bus.mode_valid = valid_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: doc/adc_mode_sequencer.md
Name: adc_mode_sequencer

Overview:
- Parametrised successor of the ADC mode-select FSM.
- Cycles through NUM_MODES converter modes (PWM ramp, PWM SAR, R2R ramp, R2R SAR, XADC, …) from next/prev pushbuttons, with wrap-around in both directions.
- Provides an index select plus one-hot enables for the mode datapaths.
- On every mode change, blanks all enables for a settle interval so analog front-ends and DACs recover before the new converter runs.

Parameters:
- NUM_MODES, 5: number of selectable modes; must be ≥ 2.
- RESET_MODE, 0: mode index loaded on reset; must be < NUM_MODES.
- SETTLE_CYCLES, 1000: blanking cycles after reset or any mode change; must be ≥ 1.
- SEL_W, $clog2(NUM_MODES): width of adc_sel (derived, not overridden).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- btn_next, in, 1: already-debounced level from the "next" button; rising edge advances the mode.
- btn_prev, in, 1: already-debounced level from the "prev" button; rising edge steps the mode back.
- adc_sel, out, SEL_W: current mode index, for the output mux.
- mode_en, out, NUM_MODES: one-hot enable for the current mode; all zero while settling.
- mode_valid, out, 1: high when state is ACTIVE.
- busy, out, 1: high when state is SETTLE; button edges are dropped while high.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = SETTLE
  - adc_sel = RESET_MODE
  - mode_en = 0
  - mode_valid = 0
  - busy = 1
  - settle counter = SETTLE_CYCLES-1
  - btn_next_q = btn_prev_q = 0
- Edge detect:
  - nxt = btn_next & ~btn_next_q; prv = btn_prev & ~btn_prev_q.
  - The _q registers sample the buttons every cycle, including during SETTLE.
  - A button held high through reset release therefore produces one edge in the first cycle after reset. That edge is dropped because the block is in SETTLE.
- States: SETTLE, ACTIVE.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0 at a clock edge, go to ACTIVE at that edge: mode_en = 1<<adc_sel, mode_valid = 1, busy = 0.
  - Settle length is exactly SETTLE_CYCLES cycles, measured from the edge that entered SETTLE.
  - nxt/prv are ignored; no queuing.
- ACTIVE, edge handling:
  - nxt only: adc_sel ← (adc_sel == NUM_MODES-1) ? 0 : adc_sel+1.
  - prv only: adc_sel ← (adc_sel == 0) ? NUM_MODES-1 : adc_sel-1.
  - nxt and prv in the same cycle: no change; stay ACTIVE.
  - Neither: hold.
- ACTIVE, on a mode change (same edge):
  - state ← SETTLE, counter ← SETTLE_CYCLES-1.
  - mode_en ← 0, mode_valid ← 0, busy ← 1.
  - Latency: button rising edge is sampled at clock edge t → new adc_sel and mode_en = 0 visible after t → mode_en for the new mode asserted after t + SETTLE_CYCLES.
- Invariants:
  - mode_en is always either 0 or exactly one-hot, matching adc_sel.
  - mode_en != 0 iff mode_valid.
  - mode_valid == ~busy.
  - adc_sel never reaches a value ≥ NUM_MODES.
- Reset mid-operation (during either state) restores all reset values on the next edge; any pending settle is discarded.
- Illegal/unreachable state encodings recover to SETTLE with adc_sel = RESET_MODE.

Optional Feature:
- Macro: ADC_MODE_AUTOSCAN_EN.
- With the macro defined:
  - Adds parameter SCAN_PERIOD (default 100000, ≥ 1).
  - Adds input auto_scan (1 bit).
  - While auto_scan = 1 and state = ACTIVE, a dwell counter counts cycles. After SCAN_PERIOD cycles in ACTIVE it generates an internal nxt, handled exactly like a button edge.
  - The dwell counter clears on entering ACTIVE, on any mode change, on reset, and whenever auto_scan = 0.
  - A button edge in the same cycle as the auto edge counts as a single nxt. If that button edge is a prv, the nxt+prv rule applies: no change.
- Without the macro: no auto_scan port, no dwell counter; behaviour is purely button-driven.

Test Plan:
- Reset release, buttons low, SETTLE_CYCLES=4 → cycles 1-4: mode_en=0, busy=1; after edge 4: mode_en=5'b00001, adc_sel=0, mode_valid=1.
- In ACTIVE, five single btn_next pulses, each after settle completes → adc_sel 1,2,3,4,0; mode_en 00010, 00100, 01000, 10000, 00001; mode_en=0 for exactly 4 cycles after each change.
- adc_sel=0, btn_prev pulse → adc_sel=4, mode_en=10000 after settle. btn_next held high for 20 cycles → exactly one advance.
- btn_next rising edge during SETTLE → dropped; adc_sel unchanged. btn_next and btn_prev rising in the same ACTIVE cycle → no change, busy stays 0.
- Reset asserted at settle count 2 with adc_sel=3 → next edge: adc_sel=0, busy=1, full SETTLE_CYCLES blanking restarts.
- ADC_MODE_AUTOSCAN_EN, SCAN_PERIOD=10, auto_scan=1 → adc_sel advances every 10+SETTLE_CYCLES cycles with wrap 4→0. auto_scan dropped at dwell count 7 → no advance, dwell counter is 0.
